// File: rtl/cpu_decode_issue.sv
// cpu_decode_issue: single-issue decode with regfile, busy scoreboard and registered execute bundle.
// Optional CPU_DECODE_WB_BYPASS_EN forwards same-cycle writeback data to sources and unblocks them.
module cpu_decode_issue #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_next_pc,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_opcode,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  out_writes_dst,
  output logic [XLEN-1:0]       out_ra_data,
  output logic [XLEN-1:0]       out_rb_data,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_next_pc,
  output logic [NUM_REGS-1:0]   busy_mask
);
  localparam int IMM_W = 25 - 3 * REG_ADDR_W;
  logic [XLEN-1:0] rf [NUM_REGS];
  logic [6:0] opcode;
  logic [REG_ADDR_W-1:0] dst, src1, src2;
  logic is_nop, is_r, is_i, is_s, use_a, use_b, writes, wb_hit, hazard, issue;
  logic [NUM_REGS-1:0] wb_mask, flush_mask, set_mask, busy_eff, busy_next;
  logic [XLEN-1:0] ra, rb, imm;
  assign opcode = in_instr[31:25];
  assign dst = in_instr[24 -: REG_ADDR_W];
  assign src1 = in_instr[24 - REG_ADDR_W -: REG_ADDR_W];
  assign src2 = in_instr[24 - 2 * REG_ADDR_W -: REG_ADDR_W];
  assign imm = {{(XLEN - IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
  assign is_nop = opcode == 7'h00;
  assign is_r = !opcode[6] && !is_nop;
  assign is_i = opcode[6:5] == 2'b10;
  assign is_s = opcode[6:5] == 2'b11;
  assign use_a = !is_nop;
  assign use_b = is_r || is_s;
  assign writes = (is_r || is_i) && dst != '0;
  assign wb_hit = wb_en && wb_addr != '0;
  assign wb_mask = wb_hit ? NUM_REGS'(1) << wb_addr : '0;
  assign flush_mask = (flush && out_valid && out_writes_dst) ? NUM_REGS'(1) << out_dst : '0;
  assign set_mask = (issue && writes) ? NUM_REGS'(1) << dst : '0;
  assign busy_next = (busy_mask & ~wb_mask & ~flush_mask) | set_mask;
`ifdef CPU_DECODE_WB_BYPASS_EN
  assign busy_eff = busy_mask & ~wb_mask;
  assign ra = (wb_hit && wb_addr == src1) ? wb_data : rf[src1];
  assign rb = (wb_hit && wb_addr == src2) ? wb_data : rf[src2];
`else
  assign busy_eff = busy_mask;
  assign ra = rf[src1];
  assign rb = rf[src2];
`endif
  assign hazard = (use_a && busy_eff[src1]) || (use_b && busy_eff[src2]) || (writes && busy_eff[dst]);
  assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
  assign issue = in_valid && in_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      busy_mask <= '0;
      out_valid <= 1'b0;
      out_opcode <= '0;
      out_dst <= '0;
      out_writes_dst <= 1'b0;
      out_ra_data <= '0;
      out_rb_data <= '0;
      out_imm <= '0;
      out_next_pc <= '0;
    end else begin
      if (wb_hit) rf[wb_addr] <= wb_data;
      busy_mask <= busy_next;
      out_valid <= !flush && (issue || (out_valid && !out_ready));
      if (issue) begin
        out_opcode <= opcode;
        out_dst <= dst;
        out_writes_dst <= writes;
        out_ra_data <= use_a ? ra : '0;
        out_rb_data <= use_b ? rb : '0;
        out_imm <= imm;
        out_next_pc <= in_next_pc;
      end
    end
  end
endmodule
